ru_write_ctrl: RTL and testbench

Write-port controller for the 32x32 register unit. Owns the register unit's single write port (`RUWr`/`Rd`/`DataWr`).
- After reset, it sequences a hardware initialisation: x1..x31 are cleared and x2 is loaded with the stack pointer value.
- Afterwards, it arbitrates the port between core writeback and an optional debug write port, with starvation protection.
- Sits between the writeback stage and `registers_unit`.

---
 rtl/ru_ctrl_pkg.sv | 25 ++
 rtl/ru_dbg_arb.sv | 45 ++++
 rtl/ru_write_ctrl.sv | 133 +++++++++++++
 tb/tb_ru_write_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ru_ctrl_pkg.sv
// Shared types and constants for the register-unit write-port controller.
// Used by ru_write_ctrl and ru_dbg_arb.
package ru_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ru_state_e;

    typedef logic [4:0] reg_addr_t;

    localparam int          XLEN_DEF    = 32;
    localparam logic [31:0] SP_INIT_DEF = 32'd1024;
    localparam int          NUM_REGS    = 32;

    localparam reg_addr_t FIRST_REG = 5'd1;
    localparam reg_addr_t SP_REG    = 5'd2;
    localparam reg_addr_t LAST_REG  = reg_addr_t'(NUM_REGS - 1);

    // x2 is the only register with a non-zero power-on value.
    function automatic logic is_sp_reg(input reg_addr_t addr);
        return addr == SP_REG;
    endfunction

endpackage

// File: rtl/ru_dbg_arb.sv
// Debug write arbitration: counts refused debug cycles and forces a grant
// (stalling the core) once a pending request has waited DBG_MAX_WAIT cycles.
module ru_dbg_arb
    import ru_ctrl_pkg::*;
#(
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic wb_en,
    input  logic dbg_req,
    output logic dbg_sel,
    output logic force_req
);

    localparam int WAIT_W = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        force_req     = run && dbg_req && (wait_cnt_reg == WAIT_MAX);
        dbg_sel       = run && dbg_req && (!wb_en || force_req);
        wait_cnt_next = wait_cnt_reg;
        // The counter only moves in RUN; during INIT a pending request waits at 0.
        if (run) begin
            if (!dbg_req || dbg_sel) begin
                wait_cnt_next = '0;
            end else if (wait_cnt_reg != WAIT_MAX) begin
                wait_cnt_next = wait_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ru_write_ctrl.sv
// Owner of the register unit's single write port: hardware init of x1..x31,
// then core writeback with an optional debug port (macro RU_DEBUG_PORT_EN).
module ru_write_ctrl
    import ru_ctrl_pkg::*;
#(
    parameter int          XLEN         = XLEN_DEF,
    parameter logic [31:0] SP_INIT      = SP_INIT_DEF,
    parameter int          DBG_MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
`ifdef RU_DEBUG_PORT_EN
    input  logic            dbg_req,
    input  logic [4:0]      dbg_rd,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_gnt,
`endif
    output logic            ru_wr,
    output logic [4:0]      ru_rd,
    output logic [XLEN-1:0] ru_data,
    output logic            stall,
    output logic            init_done
);

    ru_state_e state_reg;
    ru_state_e state_next;
    reg_addr_t init_cnt_reg;
    reg_addr_t init_cnt_next;

    logic            wr_int;
    reg_addr_t       rd_int;
    logic [XLEN-1:0] data_int;
    logic            stall_int;
    logic            done_int;
    logic            gnt_int;

`ifdef RU_DEBUG_PORT_EN
    logic dbg_sel;
    logic force_req;

    ru_dbg_arb #(
        .DBG_MAX_WAIT (DBG_MAX_WAIT)
    ) u_dbg_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (state_reg == RUN),
        .wb_en     (wb_en),
        .dbg_req   (dbg_req),
        .dbg_sel   (dbg_sel),
        .force_req (force_req)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= INIT;
            init_cnt_reg <= FIRST_REG;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        wr_int        = 1'b0;
        rd_int        = '0;
        data_int      = '0;
        stall_int     = 1'b1;
        done_int      = 1'b0;
        gnt_int       = 1'b0;
        case (state_reg)
            INIT: begin
                wr_int        = 1'b1;
                rd_int        = init_cnt_reg;
                data_int      = is_sp_reg(init_cnt_reg) ? XLEN'(SP_INIT) : '0;
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == LAST_REG) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                done_int  = 1'b1;
                stall_int = 1'b0;
`ifdef RU_DEBUG_PORT_EN
                if (dbg_sel) begin
                    // A forced grant suppresses the core write; the core re-presents it.
                    gnt_int   = 1'b1;
                    rd_int    = dbg_rd;
                    data_int  = dbg_data;
                    wr_int    = (dbg_rd != '0);
                    stall_int = force_req && wb_en;
                end else if (wb_en) begin
                    rd_int   = wb_rd;
                    data_int = wb_data;
                    wr_int   = (wb_rd != '0);
                end
`else
                if (wb_en) begin
                    rd_int   = wb_rd;
                    data_int = wb_data;
                    wr_int   = (wb_rd != '0);
                end
`endif
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Outputs are purely combinational so the register unit's same-cycle
    // forwarding still sees the write; reset overrides them immediately.
    always_comb begin
        ru_wr     = rst_n && wr_int;
        ru_rd     = rst_n ? rd_int : '0;
        ru_data   = rst_n ? data_int : '0;
        stall     = !rst_n || stall_int;
        init_done = rst_n && done_int;
    end

`ifdef RU_DEBUG_PORT_EN
    assign dbg_gnt = rst_n && gnt_int;
`else
    logic unused_gnt;
    assign unused_gnt = gnt_int;
`endif

endmodule

// File: tb/tb_ru_write_ctrl.sv
// Self-checking bench for ru_write_ctrl: init sequence, reset abort, vector
// table, starvation sequence and a randomized run against a reference model.
module tb_ru_write_ctrl;

    localparam int          XLEN = 32;
    localparam logic [31:0] SP   = 32'd1024;
    localparam int          MAXW = 8;
`ifdef RU_DEBUG_PORT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_en = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            dbg_req = 1'b0;
    logic [4:0]      dbg_rd = '0;
    logic [XLEN-1:0] dbg_data = '0;
    logic            dbg_gnt;
    logic            ru_wr;
    logic [4:0]      ru_rd;
    logic [XLEN-1:0] ru_data;
    logic            stall;
    logic            init_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ru_write_ctrl #(
        .XLEN         (XLEN),
        .SP_INIT      (SP),
        .DBG_MAX_WAIT (MAXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
`ifdef RU_DEBUG_PORT_EN
        .dbg_req   (dbg_req),
        .dbg_rd    (dbg_rd),
        .dbg_data  (dbg_data),
        .dbg_gnt   (dbg_gnt),
`endif
        .ru_wr     (ru_wr),
        .ru_rd     (ru_rd),
        .ru_data   (ru_data),
        .stall     (stall),
        .init_done (init_done)
    );

`ifndef RU_DEBUG_PORT_EN
    assign dbg_gnt = 1'b0;
`endif

    typedef struct {
        bit          wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        bit          dbg_req;
        logic [4:0]  dbg_rd;
        logic [31:0] dbg_data;
        bit          e_wr;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        bit          e_gnt;
        bit          e_stall;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare outputs at posedge+4 (inputs already set at posedge+1), then advance.
    task automatic step(input string tag, input bit e_wr, input logic [4:0] e_rd,
                        input logic [31:0] e_data, input bit e_gnt, input bit e_stall,
                        input bit e_done);
        #3;
        $display("%0t %s wr=%0b rd=%0d data=%h gnt=%0b stall=%0b done=%0b",
                 $time, tag, ru_wr, ru_rd, ru_data, dbg_gnt, stall, init_done);
        chk({tag, ".ru_wr"}, 32'(ru_wr), 32'(e_wr));
        chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'(e_gnt));
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".init_done"}, 32'(init_done), 32'(e_done));
        if (e_wr) begin
            chk({tag, ".ru_rd"}, 32'(ru_rd), 32'(e_rd));
            chk({tag, ".ru_data"}, ru_data, e_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        $display("%0t %s reset wr=%0b rd=%0d data=%h stall=%0b done=%0b",
                 $time, tag, ru_wr, ru_rd, ru_data, stall, init_done);
        chk({tag, ".ru_wr"}, 32'(ru_wr), 32'd0);
        chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd1);
        chk({tag, ".init_done"}, 32'(init_done), 32'd0);
        chk({tag, ".ru_rd"}, 32'(ru_rd), 32'd0);
        chk({tag, ".ru_data"}, ru_data, 32'd0);
    endtask

    // Expects to be called at posedge+1 just after reset release.
    // abort_at != 0 pulses reset during the cycle that writes that register.
    task automatic run_init(input int abort_at, output bit aborted);
        aborted = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            wb_en   = 1'b1;
            wb_rd   = 5'd9;
            wb_data = 32'hFFFF_0000 | 32'(k);
            if (k == abort_at) begin
                #3;
                chk($sformatf("init_pre_abort[%0d].ru_rd", k), 32'(ru_rd), 32'(k));
                rst_n = 1'b0;
                #1;
                chk_reset("abort_now");
                @(posedge clk);
                #2;
                chk_reset("abort_held");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                aborted = 1'b1;
                return;
            end
            step($sformatf("init[%0d]", k), 1'b1, 5'(k), (k == 2) ? SP : 32'd0,
                 1'b0, 1'b1, 1'b0);
        end
        wb_en = 1'b0;
        step("init_done", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic vec_t mk(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                                input bit dq, input logic [4:0] dr, input logic [31:0] dd,
                                input bit ew, input logic [4:0] er, input logic [31:0] ed,
                                input bit eg, input bit es);
        vec_t v;
        v.wb_en = we; v.wb_rd = wr; v.wb_data = wd;
        v.dbg_req = dq; v.dbg_rd = dr; v.dbg_data = dd;
        v.e_wr = ew; v.e_rd = er; v.e_data = ed; v.e_gnt = eg; v.e_stall = es;
        return v;
    endfunction

    initial begin
        bit aborted;
        int refused;
        bit pend;
        bit m_force, m_sel, e_wr, e_stall;
        logic [4:0] e_rd;
        logic [31:0] e_data;

        // ---- reset and initialisation, including an aborted init ----
        #1;
        chk_reset("in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_init(10, aborted);
        chk("abort_taken", 32'(aborted), 32'd1);
        run_init(0, aborted);

        // ---- single-cycle vectors in RUN (no debug history) ----
        tbl[0] = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
        tbl[1] = mk(1, 5'd0, 32'h1111_2222, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        tbl[2] = mk(0, 5'd4, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        tbl[3] = mk(0, 5'd0, 32'h0, 1, 5'd7, 32'h55, DBG, 5'd7, 32'h55, DBG, 0);
        tbl[4] = mk(0, 5'd0, 32'h0, 1, 5'd0, 32'h66, 0, 5'd0, 32'h0, DBG, 0);
        tbl[5] = mk(1, 5'd9, 32'h1234, 1, 5'd3, 32'h77, 1, 5'd9, 32'h1234, 0, 0);
        tbl[6] = mk(0, 5'd9, 32'h0, 1, 5'd3, 32'h77, DBG, 5'd3, 32'h77, DBG, 0);
        tbl[7] = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            wb_en = tbl[i].wb_en; wb_rd = tbl[i].wb_rd; wb_data = tbl[i].wb_data;
            dbg_req = tbl[i].dbg_req; dbg_rd = tbl[i].dbg_rd; dbg_data = tbl[i].dbg_data;
            step($sformatf("vec[%0d]", i), tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_data,
                 tbl[i].e_gnt, tbl[i].e_stall, 1'b1);
        end

        // ---- starvation: two back-to-back rounds under continuous wb_en ----
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i <= MAXW; i++) begin
                wb_en = 1'b1; wb_rd = 5'(10 + i); wb_data = 32'hC0DE_0000 | 32'(i);
                dbg_req = 1'b1; dbg_rd = 5'd12; dbg_data = 32'hA5A5_0000 | 32'(r);
                if (DBG && i == MAXW)
                    step($sformatf("starve[%0d][%0d]", r, i), 1'b1, 5'd12, dbg_data,
                         1'b1, 1'b1, 1'b1);
                else
                    step($sformatf("starve[%0d][%0d]", r, i), 1'b1, wb_rd, wb_data,
                         1'b0, 1'b0, 1'b1);
            end
        end
        dbg_req = 1'b0;
        step("starve_replay", 1'b1, wb_rd, wb_data, 1'b0, 1'b0, 1'b1);

        // ---- randomized traffic against the reference model ----
        refused = 0;
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            wb_en   = ($urandom_range(0, 3) != 0);
            wb_rd   = 5'($urandom);
            wb_data = $urandom;
            if (DBG) begin
                if (!pend && $urandom_range(0, 3) == 0) begin
                    pend = 1'b1;
                    dbg_rd = 5'($urandom);
                    dbg_data = $urandom;
                end else if (pend && $urandom_range(0, 15) == 0) begin
                    pend = 1'b0;
                end
            end
            dbg_req = pend;
            // A pending request that has been turned away MAXW times in a row wins.
            m_force = pend && (refused >= MAXW);
            m_sel   = pend && (!wb_en || m_force);
            e_stall = m_sel && wb_en;
            e_rd    = m_sel ? dbg_rd : wb_rd;
            e_data  = m_sel ? dbg_data : wb_data;
            e_wr    = (m_sel || wb_en) && (e_rd != 5'd0);
            step($sformatf("rand[%0d]", c), e_wr, e_rd, e_data, m_sel, e_stall, 1'b1);
            if (!pend || m_sel) refused = 0;
            else if (refused < MAXW) refused++;
            if (m_sel) pend = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
